// File: rtl/pc_redirect_pkg.sv
// Shared types for the execute-to-fetch redirect path: condition codes, FSM states, ALU flag positions.
package pc_redirect_pkg;

    typedef enum logic [2:0] {
        EQ  = 3'd0,
        NE  = 3'd1,
        LT  = 3'd2,
        GE  = 3'd3,
        LTU = 3'd4,
        GEU = 3'd5,
        AL  = 3'd6,
        NV  = 3'd7
    } cond_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_e;

    // Bit positions inside the {Z,N,C,V} flag nibble
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/pc_redirect_unit_branch_cond_eval.sv
// Condition-code evaluator: maps cond_e plus ALU flags to a taken bit.
// Purely combinational, no latency, no backpressure.
module branch_cond_eval
    import pc_redirect_pkg::*;
(
    input  cond_e      ex_cond,
    input  logic [3:0] ex_flags,
    output logic       cond_true
);

    logic z, n, c, v;

    assign z = ex_flags[FLAG_Z];
    assign n = ex_flags[FLAG_N];
    assign c = ex_flags[FLAG_C];
    assign v = ex_flags[FLAG_V];

    always_comb begin
        cond_true = 1'b0;
        case (ex_cond)
            EQ:      cond_true = z;
            NE:      cond_true = ~z;
            LT:      cond_true = n ^ v;
            GE:      cond_true = ~(n ^ v);
            LTU:     cond_true = ~c;
            GEU:     cond_true = c;
            AL:      cond_true = 1'b1;
            NV:      cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Resolves execute-stage branches/jumps into a registered fetch redirect plus a flush window.
// Latency 1 cycle from accept; redirect held while stall=1; ex_* ignored while busy.
module pc_redirect_unit
    import pc_redirect_pkg::*;
#(
    parameter int N           = 32,
    parameter int FLUSH_SLOTS = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_is_jump,
    input  logic             ex_is_branch,
    input  logic [2:0]       ex_cond,
    input  logic [3:0]       ex_flags,
    input  logic [N-1:0]     ex_pc,
    input  logic [N-1:0]     ex_offset,
    input  logic             stall,
    output logic [N-1:0]     jmp_pc,
    output logic             pc_selector,
    output logic             flush,
    output logic             busy,
    output logic             misalign_err,
    output logic [CNT_W-1:0] redirect_count
);

    localparam int FC_W = (FLUSH_SLOTS > 0) ? $clog2(FLUSH_SLOTS + 1) : 1;

    state_e           state_q, state_d;
    logic [N-1:0]     jmp_q, jmp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic             sel_q, sel_d;
    logic             flush_q, flush_d;
    logic             busy_q, busy_d;
    logic             mis_q, mis_d;

    logic             cond_true;
    logic             take;
    logic [N-1:0]     target;

    branch_cond_eval u_cond (
        .ex_cond   (cond_e'(ex_cond)),
        .ex_flags  (ex_flags),
        .cond_true (cond_true)
    );

    assign take   = ex_valid & (ex_is_jump | (ex_is_branch & cond_true));
    // Carry out is dropped on purpose: targets wrap modulo 2^N
    assign target = ex_pc + ex_offset;

    always_comb begin
        state_d = state_q;
        jmp_d   = jmp_q;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        mis_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (take) begin
                    if (target[1:0] == 2'b00) begin
                        jmp_d   = target;
                        state_d = REDIRECT;
                        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
                    end else begin
                        mis_d = 1'b1;
                    end
                end
            end
            REDIRECT: begin
                if (!stall) begin
                    if (FLUSH_SLOTS > 0) begin
                        state_d = FLUSH;
                        fcnt_d  = FC_W'(FLUSH_SLOTS);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (!stall) begin
                    if (fcnt_q == FC_W'(1)) begin
                        state_d = IDLE;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        sel_d   = (state_d == REDIRECT);
        flush_d = (state_d != IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            jmp_q   <= '0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            sel_q   <= 1'b0;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            jmp_q   <= jmp_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            sel_q   <= sel_d;
            flush_q <= flush_d;
            busy_q  <= busy_d;
            mis_q   <= mis_d;
        end
    end

    assign jmp_pc         = jmp_q;
    assign pc_selector    = sel_q;
    assign flush          = flush_q;
    assign busy           = busy_q;
    assign misalign_err   = mis_q;
    assign redirect_count = cnt_q;

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Resolves branches and jumps at the end of execute and drives the fetch stage's redirect interface (jmp_pc, pc_selector).
- Registers one redirect at a time and holds it across stalls.
- Issues a flush window to the younger pipeline slots and counts taken redirects for performance monitoring.
- Sits between the execute stage and the instruction fetch stage of the ASIP pipeline.

Parameters:
- N, 32, datapath/address width in bits.
- FLUSH_SLOTS, 2, number of unstalled cycles flush stays asserted after the redirect is consumed (0 allowed).
- CNT_W, 8, width of the saturating redirect counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ex_valid  input  1  execute stage holds a valid instruction this cycle.
- ex_is_jump  input  1  unconditional jump.
- ex_is_branch  input  1  conditional branch; ignored if ex_is_jump=1.
- ex_cond  input  3  condition code (cond_e).
- ex_flags  input  4  {Z,N,C,V} from the ALU.
- ex_pc  input  N  PC of the execute instruction.
- ex_offset  input  N  pre-sign-extended byte offset.
- stall  input  1  pipeline freeze; fetch does not consume a redirect while high.
- jmp_pc  output  N  registered redirect target.
- pc_selector  output  1  1 = fetch takes jmp_pc.
- flush  output  1  kill younger in-flight instructions.
- busy  output  1  state != IDLE.
- misalign_err  output  1  one-cycle pulse on a misaligned target.
- redirect_count  output  CNT_W  saturating count of accepted redirects.

Behaviour:
- Reset (asynchronous): state=IDLE, jmp_pc=0, pc_selector=0, flush=0, misalign_err=0, redirect_count=0, flush counter=0.
- All outputs are registered.

Taken and target rules:
- take = ex_valid & (ex_is_jump | (ex_is_branch & cond_true)).
- target = (ex_pc + ex_offset) mod 2^N; carry is discarded, so wrap-around is legal.
- cond_true by ex_cond:
  - 000 EQ: Z
  - 001 NE: !Z
  - 010 LT: N^V
  - 011 GE: !(N^V)
  - 100 LTU: !C
  - 101 GEU: C
  - 110 AL: 1
  - 111 NV: 0

FSM states and transitions:
- IDLE:
  - If take and target[1:0]==0: latch target into jmp_pc and go to REDIRECT. pc_selector=1 and flush=1 from the next cycle (latency 1). redirect_count increments unless saturated at all-ones.
  - If take and target[1:0]!=0: misalign_err=1 for the next cycle only, no redirect, stay in IDLE.
  - stall does not block acceptance in IDLE.
- REDIRECT:
  - pc_selector=1, flush=1, jmp_pc held.
  - stall=1: remain in REDIRECT; outputs held.
  - stall=0: fetch consumes the redirect this cycle.
    - FLUSH_SLOTS>0: go to FLUSH, counter=FLUSH_SLOTS.
    - FLUSH_SLOTS=0: go to IDLE.
- FLUSH:
  - pc_selector=0, flush=1.
  - Counter decrements only on stall=0 cycles.
  - On counter==1 with stall=0: go to IDLE (flush=0 next cycle).
- While busy, all ex_* inputs are ignored: those instructions are wrong-path and are being flushed, so redirect_count does not change.
- Simultaneous events:
  - A take in the same cycle the FSM returns to IDLE is ignored; acceptance needs state==IDLE at the sampling edge.
  - reset has priority over everything.
  - reset mid-REDIRECT or mid-FLUSH drops the pending redirect immediately (asynchronous).

Decomposition:
- Package pc_redirect_pkg:
  - cond_e enum (EQ, NE, LT, GE, LTU, GEU, AL, NV).
  - state_e enum (IDLE, REDIRECT, FLUSH).
  - Flag bit index constants FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0.
- One combinational sub-module, branch_cond_eval (ex_cond, ex_flags -> cond_true).
- Reuse the existing adder for target computation.

Test Plan:
- Jump, no stall: ex_valid=1, ex_is_jump=1, ex_pc=0x100, ex_offset=0x40.
  - Next cycle: jmp_pc=0x140, pc_selector=1, flush=1.
  - Following 2 cycles: pc_selector=0, flush=1.
  - Then busy=0 and redirect_count=1.
- Branch conditions: BEQ with Z=1 -> redirect; BEQ with Z=0 -> no redirect. LT with N=1,V=0 -> taken; GEU with C=0 -> not taken; NV never taken.
- Stall hold: accept a redirect to 0x200, then stall=1 for 3 cycles.
  - pc_selector=1 and jmp_pc=0x200 held throughout.
  - After stall drops, flush lasts exactly 2 further unstalled cycles.
- Misalign and wrap:
  - ex_pc=0x10, ex_offset=0x2 -> misalign_err pulse for 1 cycle, pc_selector stays 0, count unchanged.
  - ex_pc=0xFFFFFFFC, ex_offset=0x8 -> jmp_pc=0x4.
- Busy ignore and saturation:
  - A second jump while busy -> no change to jmp_pc or count.
  - 300 accepted redirects -> redirect_count=255.
- Async reset asserted mid-REDIRECT, between clock edges -> pc_selector, flush and busy drop to 0 immediately; a jump after release is accepted normally.
